// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with registered one-hot/encoded grant,
// release on done or dropped request, and a hold-time watchdog.
module rr_arbiter8 #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CW       = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       gnt_valid,
   output logic       timeout
);

   localparam int unsigned N  = 8;
   localparam int unsigned IW = 3;

   typedef enum logic {IDLE, GRANT} state_e;

   state_e          state_q;
   logic [N-1:0]    gnt_q;
   logic [IW-1:0]   gnt_id_q;
   logic            gnt_valid_q;
   logic            timeout_q;
   logic [IW-1:0]   ptr_q;
   logic [CW-1:0]   cnt_q;

   logic [IW-1:0]   idx_c;
   logic [IW-1:0]   win_c;
   logic            found_c;
   logic            owner_req_c;
   logic            wd_c;
   logic            release_c;

   // First requester at or after ptr, wrapping 7->0
   always_comb begin
      idx_c   = '0;
      win_c   = '0;
      found_c = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         idx_c = ptr_q + IW'(i);
         if (!found_c && req[idx_c]) begin
            found_c = 1'b1;
            win_c   = idx_c;
         end
      end
   end

   // Release causes for the current owner
   always_comb begin
      owner_req_c = req[gnt_id_q];
      wd_c        = (MAX_HOLD != 0) && (cnt_q == CW'(MAX_HOLD - 1));
      release_c   = done || !owner_req_c || wd_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         gnt_id_q    <= '0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         ptr_q       <= '0;
         cnt_q       <= '0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (found_c) begin
                  state_q     <= GRANT;
                  gnt_q       <= N'(1) << win_c;
                  gnt_id_q    <= win_c;
                  gnt_valid_q <= 1'b1;
                  cnt_q       <= '0;
               end
            end
            GRANT: begin
               if (release_c) begin
                  state_q     <= IDLE;
                  gnt_q       <= '0;
                  gnt_id_q    <= '0;
                  gnt_valid_q <= 1'b0;
                  ptr_q       <= gnt_id_q + IW'(1);
                  // Forced revocation only when the owner neither finished nor withdrew
                  timeout_q   <= wd_c && !done && owner_req_c;
               end else if (cnt_q != CW'(MAX_HOLD)) begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign gnt_valid = gnt_valid_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: a transaction-level owner/pointer model
// predicts every cycle's outputs; a monitor pops and compares after each edge.
module tb_rr_arbiter8;

   localparam int unsigned MAX_HOLD = 16;

   typedef struct packed {
      logic [7:0] gnt;
      logic [2:0] id;
      logic       v;
      logic       to;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] req = '0;
   logic       done = 1'b0;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   int n_cmp = 0;
   int n_err = 0;

   exp_t exp_q[$];

   // Model: who owns the resource, for how many visible cycles, and where to scan next
   int owner = -1;
   int held  = 0;
   int ptr   = 0;

   rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CW(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .done     (done),
      .gnt      (gnt),
      .gnt_id   (gnt_id),
      .gnt_valid(gnt_valid),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input exp_t e);
      n_cmp++;
      if (gnt !== e.gnt || gnt_id !== e.id || gnt_valid !== e.v || timeout !== e.to) begin
         n_err++;
         $display("FAIL %s t=%0t: got gnt=%h id=%0d v=%b to=%b, want gnt=%h id=%0d v=%b to=%b",
                  name, $time, gnt, gnt_id, gnt_valid, timeout, e.gnt, e.id, e.v, e.to);
      end
   endtask

   // Advance the model by one edge with the inputs that edge will sample
   task automatic model_edge(input logic [7:0] r, input logic d, output exp_t e);
      logic to;
      logic wd;
      to = 1'b0;
      if (owner < 0) begin
         if (r != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
               int c;
               c = (ptr + k) % 8;
               if (r[c]) begin
                  owner = c;
                  held  = 1;
                  break;
               end
            end
         end
      end else begin
         wd = (MAX_HOLD != 0) && (held == int'(MAX_HOLD));
         if (d || !r[owner] || wd) begin
            to    = !d && r[owner] && wd;
            ptr   = (owner + 1) % 8;
            owner = -1;
            held  = 0;
         end else begin
            held++;
         end
      end
      e.gnt = (owner >= 0) ? (8'(1) << owner) : 8'h00;
      e.id  = (owner >= 0) ? 3'(owner) : 3'd0;
      e.v   = (owner >= 0);
      e.to  = to;
   endtask

   task automatic step(input logic [7:0] r, input logic d);
      exp_t e;
      @(posedge clk);
      #2;
      req  = r;
      done = d;
      model_edge(r, d, e);
      exp_q.push_back(e);
   endtask

   // Asynchronous reset mid-cycle; outputs must clear without a clock edge
   task automatic do_reset();
      exp_t z;
      z = '0;
      @(posedge clk);
      #2;
      req   = '0;
      done  = 1'b0;
      rst_n = 1'b0;
      #1;
      check("async_reset", z);
      exp_q.delete();
      owner = -1;
      held  = 0;
      ptr   = 0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // Monitor: compare one expected entry per clock edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && exp_q.size() > 0) check("cycle", exp_q.pop_front());
      end
   end

   initial begin
      logic [7:0] r;
      logic       d;
      do_reset();

      // Single requester: grant 4 after one edge
      step(8'h10, 1'b0);
      step(8'h10, 1'b1);
      step(8'h00, 1'b0);

      // All requesting, done two cycles into each grant: strict rotation
      for (int i = 0; i < 40; i++) begin
         d = (owner >= 0) && (held == 2);
         step(8'hFF, d);
      end
      step(8'h00, 1'b0);
      step(8'h00, 1'b0);

      // Pointer wrap: after 6, scan 7,0; after 0, scan reaches 6
      do_reset();
      step(8'h40, 1'b0);
      step(8'h40, 1'b1);
      step(8'h41, 1'b0);
      step(8'h41, 1'b0);
      step(8'h41, 1'b1);
      step(8'h41, 1'b0);
      step(8'h41, 1'b1);
      step(8'h00, 1'b0);

      // Watchdog: held request with no done, twice in a row
      for (int i = 0; i < 40; i++) step(8'h04, 1'b0);
      // done coinciding with the watchdog cycle is a normal release
      for (int i = 0; i < 20; i++) step(8'h04, (owner >= 0) && (held == int'(MAX_HOLD)));
      step(8'h00, 1'b0);
      step(8'h00, 1'b0);

      // Owner drops request; done in idle is ignored
      step(8'h08, 1'b0);
      step(8'h08, 1'b0);
      step(8'h00, 1'b0);
      step(8'h00, 1'b1);
      step(8'h00, 1'b0);
      step(8'h18, 1'b0);
      step(8'h18, 1'b1);
      step(8'h00, 1'b0);

      // Reset mid-grant of requester 5, then full request restarts at 0
      step(8'h20, 1'b0);
      step(8'h20, 1'b0);
      do_reset();
      step(8'hFF, 1'b0);
      step(8'hFF, 1'b1);
      step(8'h00, 1'b0);

      // Random traffic with frequent releases
      r = 8'h00;
      for (int i = 0; i < 800; i++) begin
         r = r ^ 8'($urandom & $urandom & $urandom);
         d = ($urandom_range(0, 5) == 0);
         step(r, d);
         if (i == 400) do_reset();
      end

      // Random traffic with rare done so the watchdog fires
      r = 8'hFF;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) r = r ^ (8'(1) << $urandom_range(0, 7));
         d = ($urandom_range(0, 49) == 0);
         step(r, d);
      end
      step(8'h00, 1'b0);

      @(posedge clk);
      #3;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
